// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decoder with a sequenced RV M-extension multiply/divide engine.
// Base ops decode combinationally; M ops stall the pipeline until the engine finishes.
module alu_mdu_control #(
   parameter int unsigned XLEN     = 32,
   parameter bit          ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [1:0]      ALUOp,
   input  logic [2:0]      F3,
   input  logic            b,
   input  logic            m,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [3:0]      ALU_Sel,
   output logic            is_mdu,
   output logic            stall,
   output logic            mdu_done,
   output logic [XLEN-1:0] mdu_result
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam int unsigned CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0]            op_q, op_d;
   logic                  neg_q, neg_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [XLEN-1:0]       mcand_q, mcand_d;
   logic [XLEN-1:0]       result_q, result_d;

   logic                  accept;
   logic                  a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]       a_mag, b_mag;
   logic                  div_zero, div_ovf, special;
   logic [XLEN-1:0]       special_res;
   logic [XLEN:0]         mul_sum, div_trial;
   logic [2*XLEN-1:0]     mul_step, div_step, prod_fin;
   logic [XLEN-1:0]       div_sel, mul_res, div_res;

   // Base decode; M ops force ADD so the ALU path stays benign
   always_comb begin
      is_mdu  = ENABLE_M & (ALUOp == 2'b10) & m;
      ALU_Sel = ALU_ADD;
      case (ALUOp)
         2'b00: ALU_Sel = ALU_ADD;
         2'b01: ALU_Sel = ALU_SUB;
         default: begin
            case (F3)
               3'b000:  ALU_Sel = (b && ALUOp == 2'b10) ? ALU_SUB : ALU_ADD;
               3'b001:  ALU_Sel = ALU_SLL;
               3'b010:  ALU_Sel = ALU_SLT;
               3'b011:  ALU_Sel = ALU_SLTU;
               3'b100:  ALU_Sel = ALU_XOR;
               3'b101:  ALU_Sel = b ? ALU_SRA : ALU_SRL;
               3'b110:  ALU_Sel = ALU_OR;
               default: ALU_Sel = ALU_AND;
            endcase
         end
      endcase
      if (is_mdu) ALU_Sel = ALU_ADD;
   end

   always_comb begin
      accept      = in_valid & is_mdu & ~flush;
      a_sgn       = (F3 == 3'b001) | (F3 == 3'b010) | (F3 == 3'b100) | (F3 == 3'b110);
      b_sgn       = (F3 == 3'b001) | (F3 == 3'b100) | (F3 == 3'b110);
      a_neg       = a_sgn & op_a[XLEN-1];
      b_neg       = b_sgn & op_b[XLEN-1];
      a_mag       = a_neg ? -op_a : op_a;
      b_mag       = b_neg ? -op_b : op_b;
      div_zero    = F3[2] & (op_b == '0);
      div_ovf     = F3[2] & ~F3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
      special     = div_zero | div_ovf;
      special_res = div_zero ? (F3[1] ? op_a : '1) : (F3[1] ? '0 : op_a);
   end

   // One iteration of shift-add multiply and restoring divide on acc_q
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
      mul_step  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mcand_q};
      div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod_fin  = neg_q ? -mul_step : mul_step;
      mul_res   = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
      div_sel   = op_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
      div_res   = neg_q ? -div_sel : div_sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (special)    state_d = ST_DONE;
               else if (F3[2]) state_d = ST_DIV;
               else            state_d = ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush)                    state_d = ST_IDLE;
            else if (cnt_q == CW'(1))     state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = F3;
               neg_d   = (F3[2] & F3[1]) ? a_neg : (a_neg ^ b_neg);
               cnt_d   = special ? '0 : CW'(XLEN);
               acc_d   = F3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
               mcand_d = F3[2] ? b_mag : a_mag;
               if (special) result_d = special_res;
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
               acc_d = (state_q == ST_MUL) ? mul_step : div_step;
               if (cnt_q == CW'(1))
                  result_d = (state_q == ST_MUL) ? mul_res : div_res;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      stall      = rst_n & ((state_q == ST_IDLE & accept) | state_q == ST_MUL | state_q == ST_DIV);
      mdu_done   = (state_q == ST_DONE) & ~flush;
      mdu_result = result_q;
   end

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: base decode, M-op results/latency, special cases,
// flush, reset mid-op, and the ENABLE_M=0 variant.
module tb_alu_mdu_control;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                          XOR_ = 4'd5, SRL = 4'd6, SRA = 4'd7, OR_ = 4'd8, AND_ = 4'd9;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_valid0, flush, b, m;
   logic [1:0]  ALUOp;
   logic [2:0]  F3;
   logic [31:0] op_a, op_b;

   logic [3:0]  alu_sel, alu_sel0;
   logic        is_mdu, stall, mdu_done, is_mdu0, stall0, mdu_done0;
   logic [31:0] mdu_result, mdu_result0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_mdu_control #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .ALUOp(ALUOp),
      .F3(F3), .b(b), .m(m), .op_a(op_a), .op_b(op_b), .ALU_Sel(alu_sel),
      .is_mdu(is_mdu), .stall(stall), .mdu_done(mdu_done), .mdu_result(mdu_result)
   );

   alu_mdu_control #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .flush(flush), .ALUOp(ALUOp),
      .F3(F3), .b(b), .m(m), .op_a(op_a), .op_b(op_b), .ALU_Sel(alu_sel0),
      .is_mdu(is_mdu0), .stall(stall0), .mdu_done(mdu_done0), .mdu_result(mdu_result0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one M op at the current cycle and follow it to mdu_done
   task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] bb, input logic [31:0] exp, input int exp_done);
      int          stalls;
      int          done_cyc;
      logic [31:0] res;
      in_valid = 1'b1; ALUOp = 2'b10; m = 1'b1; b = 1'b0; F3 = f3; op_a = a; op_b = bb;
      stalls = 0; done_cyc = -1; res = '0;
      #1;
      chk({tag, "_is_mdu"}, is_mdu, 1'b1);
      chk({tag, "_alu_sel"}, alu_sel, ADD);
      for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (mdu_done) begin
            done_cyc = cyc;
            res      = mdu_result;
         end
         next_cycle();
         in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0; F3 = 3'b111;
      end
      chk({tag, "_done_cyc"}, done_cyc, exp_done);
      chk({tag, "_stalls"}, stalls, exp_done);
      chk({tag, "_res"}, res, exp);
   endtask

   logic [1:0] v_op  [13] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
   logic [2:0] v_f3  [13] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b101, 3'b001, 3'b010,
                              3'b011, 3'b100, 3'b110, 3'b111, 3'b111, 3'b010};
   logic       v_b   [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] v_exp [13] = '{SUB, ADD, ADD, SRA, SRL, SLL, SLT,
                              SLTU, XOR_, OR_, AND_, ADD, SUB};

   initial begin
      int done_seen;
      rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; flush = 1'b0;
      ALUOp = 2'b00; F3 = 3'b000; b = 1'b0; m = 1'b0; op_a = '0; op_b = '0;
      next_cycle();
      next_cycle();
      chk("rst_done", mdu_done, 1'b0);
      chk("rst_result", mdu_result, 32'h0);
      in_valid = 1'b1; ALUOp = 2'b10; m = 1'b1;
      #1;
      chk("rst_stall_forced_low", stall, 1'b0);
      in_valid = 1'b0; m = 1'b0;
      rst_n = 1'b1;
      next_cycle();

      in_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         ALUOp = v_op[i]; F3 = v_f3[i]; b = v_b[i];
         #2;
         chk($sformatf("base_sel_%0d", i), alu_sel, v_exp[i]);
         chk($sformatf("base_is_mdu_%0d", i), is_mdu, 1'b0);
         chk($sformatf("base_stall_%0d", i), stall, 1'b0);
      end
      ALUOp = 2'b11; F3 = 3'b000; m = 1'b1;
      #2;
      chk("itype_m_bit_not_mdu", is_mdu, 1'b0);
      in_valid = 1'b0; m = 1'b0;
      next_cycle();

      run_mop("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_mop("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_mop("mul",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      run_mop("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_mop("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_mop("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_mop("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_mop("rem0",   3'b110, 32'd5,         32'd0,         32'd5,         1);
      run_mop("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_mop("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_mop("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_mop("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
      run_mop("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);

      // Flush a DIV in its tenth cycle
      in_valid = 1'b1; ALUOp = 2'b10; m = 1'b1; F3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) flush = 1'b1;
         @(negedge clk);
         if (mdu_done) done_seen++;
         if (c == 10) chk("flush_stall_c10", stall, 1'b1);
         if (c == 11) chk("flush_idle_c11", stall, 1'b0);
         next_cycle();
         in_valid = 1'b0; flush = 1'b0;
      end
      chk("flush_no_done", done_seen, 0);
      chk("flush_result_kept", mdu_result, 32'd2);

      // Reset in cycle 5 of a MUL
      in_valid = 1'b1; F3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      for (int c = 0; c < 7; c++) begin
         if (c == 5) rst_n = 1'b0;
         if (c == 6) rst_n = 1'b1;
         @(negedge clk);
         if (c == 4) chk("rst_mid_busy", stall, 1'b1);
         if (c == 5) chk("rst_mid_stall_low", stall, 1'b0);
         if (c == 6) begin
            chk("rst_after_stall", stall, 1'b0);
            chk("rst_after_done", mdu_done, 1'b0);
            chk("rst_after_result", mdu_result, 32'h0);
         end
         next_cycle();
         in_valid = 1'b0;
      end
      run_mop("mul_after_rst", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 33);

      // Variant without the M engine
      in_valid = 1'b0; in_valid0 = 1'b1; ALUOp = 2'b10; m = 1'b1; F3 = 3'b000; b = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("nom_sel_%0d", c), alu_sel0, ADD);
         chk($sformatf("nom_is_mdu_%0d", c), is_mdu0, 1'b0);
         chk($sformatf("nom_stall_%0d", c), stall0, 1'b0);
         next_cycle();
      end
      b = 1'b1;
      #2;
      chk("nom_sub", alu_sel0, SUB);
      chk("nom_done", mdu_done0, 1'b0);
      in_valid0 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
